// File: rtl/seg_display_driver.sv
// ============================================================================
// Module   : seg_display_driver
// Brief    : Free-running counter source plus 4-digit multiplexed 7-seg driver
//            with a frame-synchronous shadow of the logic unit result/parity.
//            Optional macro SEG_LEADING_ZERO_BLANK_EN blanks a zero high digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned COUNT_DIV   = 50000000
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic [7:0]  result_pi,
  input  logic        p_en_pi,
  input  logic        p_value_pi,
  input  logic        hold_pi,
  output logic [15:0] counter_po,
  output logic [3:0]  an_po,
  output logic [6:0]  seg_po
);

  localparam int unsigned c_RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned c_CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [c_RW-1:0] c_R_LAST = c_RW'(REFRESH_DIV - 1);
  localparam logic [c_CW-1:0] c_C_LAST = c_CW'(COUNT_DIV - 1);
  localparam logic [6:0] c_BLANK = 7'b1111111;
  localparam logic [6:0] c_P     = 7'b0001100;

  logic [c_CW-1:0] r_cnt_pre;
  logic [15:0]     r_counter;
  logic [c_RW-1:0] r_ref_pre;
  logic [1:0]      r_idx;
  logic [7:0]      r_sh_res;
  logic            r_sh_pen;
  logic            r_sh_pval;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;

  logic            w_tick;
  logic            w_load;
  logic [1:0]      w_idx_next;
  logic [3:0]      w_lo;
  logic [6:0]      w_seg;
  logic [3:0]      w_an;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = c_BLANK;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = c_BLANK;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_ref_pre == c_R_LAST);
  assign w_load     = (r_idx == 2'd3);
  assign w_idx_next = r_idx + 2'd1;
  // Digit 0 is registered on the load tick, so it must see the incoming value.
  assign w_lo       = w_load ? result_pi[3:0] : r_sh_res[3:0];

  always_comb begin
    w_seg = c_BLANK;
    w_an  = ~(4'b0001 << w_idx_next);
    case (w_idx_next)
      2'd0: w_seg = hex7(w_lo);
      2'd1: begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_seg = (r_sh_res[7:4] == 4'h0) ? c_BLANK : hex7(r_sh_res[7:4]);
`else
        w_seg = hex7(r_sh_res[7:4]);
`endif
      end
      2'd2: w_seg = r_sh_pen ? (r_sh_pval ? 7'b1111001 : 7'b1000000) : c_BLANK;
      2'd3: w_seg = r_sh_pen ? c_P : c_BLANK;
      default: w_seg = c_BLANK;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      r_cnt_pre <= '0;
      r_counter <= '0;
    end else if (!hold_pi) begin
      if (r_cnt_pre == c_C_LAST) begin
        r_cnt_pre <= '0;
        r_counter <= r_counter + 16'd1;
      end else begin
        r_cnt_pre <= r_cnt_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      r_ref_pre <= '0;
      r_idx     <= 2'd3;
      r_sh_res  <= '0;
      r_sh_pen  <= 1'b0;
      r_sh_pval <= 1'b0;
      r_an      <= 4'b1111;
      r_seg     <= c_BLANK;
    end else if (w_tick) begin
      r_ref_pre <= '0;
      r_idx     <= w_idx_next;
      r_an      <= w_an;
      r_seg     <= w_seg;
      if (w_load) begin
        r_sh_res  <= result_pi;
        r_sh_pen  <= p_en_pi;
        r_sh_pval <= p_value_pi;
      end
    end else begin
      r_ref_pre <= r_ref_pre + 1'b1;
    end
  end

  assign counter_po = r_counter;
  assign an_po      = r_an;
  assign seg_po     = r_seg;

endmodule

`default_nettype wire

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Sequential stage around the logic unit on the seven-segment board build.
- Upstream role: generates the free-running 16-bit counter_po that feeds the logic unit's counter_pi input (the default-case result).
- Downstream role: consumes the logic unit's 8-bit result and its parity outputs (p_en, p_value), and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Frame-synchronous shadow register: the displayed value never tears mid-scan.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot (1 kHz/digit at 100 MHz); legal range >= 2.
- COUNT_DIV, 50000000, clocks per counter_po increment; legal range >= 1.

Ports:
- clk_pi  input  1  system clock; all logic is on the rising edge.
- reset_pi  input  1  synchronous, active-high reset.
- result_pi  input  8  logic unit result_po.
- p_en_pi  input  1  logic unit p_en.
- p_value_pi  input  1  logic unit p_value.
- hold_pi  input  1  1 = freeze counter_po and its prescaler.
- counter_po  output  16  free-running count; feeds logic unit counter_pi.
- an_po  output  4  digit enables, active low; an_po[0] is the rightmost digit.
- seg_po  output  7  cathodes {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (sampled at clk edge, overrides everything, including mid-scan and mid-count):
  - counter_po=0, count prescaler=0, refresh prescaler=0, digit index idx=3.
  - shadow registers=0; an_po=4'b1111; seg_po=7'b1111111.
- Counter:
  - Prescaler counts 0..COUNT_DIV-1.
  - On the edge where prescaler==COUNT_DIV-1 and hold_pi=0: prescaler<=0 and counter_po<=counter_po+1, wrapping 16'hFFFF->0.
  - hold_pi=1 freezes both the prescaler and counter_po; counting resumes from the frozen values.
  - COUNT_DIV=1 increments counter_po every unheld clock.
- Refresh:
  - Prescaler counts 0..REFRESH_DIV-1; tick = (prescaler==REFRESH_DIV-1).
  - On a tick: prescaler<=0 and idx<=idx+1 mod 4 (3->0 wraps).
  - an_po and seg_po are registered and change only on tick edges. The value registered is for the new idx.
  - First tick after reset selects digit 0. Outputs stay blank for REFRESH_DIV clocks after reset deassertion.
- Shadow load (frame sync):
  - On the tick where idx goes 3->0, shadow <= {result_pi, p_en_pi, p_value_pi}.
  - Digit 0's segments on that same tick are decoded from the incoming result_pi, not the old shadow.
  - Input changes at any other time do not affect the display until the next frame.
- Digit content, with an_po one-hot low at the selected position:
  - idx0: hex of shadow result[3:0].
  - idx1: hex of shadow result[7:4].
  - idx2: if shadow p_en, then '1' when p_value=1, else '0'; blank if p_en=0.
  - idx3: 'P' (7'b0001100) if shadow p_en; blank otherwise.
  - Blank = seg_po 7'b1111111 with an_po still selecting the digit.
- Hex decode (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous counter wrap and refresh tick: the two are independent; both update on the same edge.
- Exactly one an_po bit is low at all times after the first tick; never zero or two bits low.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit 1 is blanked when shadow result[7:4]==0. Digit 0 is always shown, so "05" is displayed as "5".
- Undefined: digit 1 always shows the hex of result[7:4], including 0.

Test Plan:
- Reset hold, then release with REFRESH_DIV=4:
  - an_po=1111 and seg_po=1111111 for 4 clocks.
  - Then an_po=1110, seg_po=1000000 (result_pi=0).
- result_pi=8'h3A, p_en_pi=1, p_value_pi=0, one full frame after load:
  - an 1110 -> seg 0001000 (A); an 1101 -> seg 0110000 (3).
  - an 1011 -> seg 1000000 (0); an 0111 -> seg 0001100 (P).
  - Frame then repeats.
- Change result_pi from 8'h3A to 8'h7F while idx=1: digits keep showing 3A until the 3->0 tick. The next digit 0 shows F, then 7.
- COUNT_DIV=3: counter_po increments every 3 clocks. With counter_po preloaded near 16'hFFFF it wraps to 16'h0000. hold_pi=1 for 10 clocks leaves counter_po unchanged; after release the next increment comes 3 - frozen_prescaler clocks later.
- Assert reset_pi mid-frame at idx=2 with counter_po=16'h0042: the next edge gives all outputs at reset values and counter_po=0.
- p_en_pi=0 with result_pi=8'h05:
  - Digits 2 and 3 are blank.
  - Digit 1 is blank with SEG_LEADING_ZERO_BLANK_EN defined, or shows 1000000 without it.
